// File: rtl/btn_cmd_in.sv
// Five-button command front end: synchronize, debounce, detect presses, queue codes in a 4-deep FIFO.
// Optional auto-repeat of the lowest held button is enabled by defining BTN_CMD_REPEAT_EN.
module btn_cmd_in #(
  parameter int DB_CYCLES  = 16,
  parameter int RPT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn,
  input  logic       ack,
  output logic [2:0] cmd,
  output logic       valid,
  output logic [2:0] level,
  output logic       ovf
);

  localparam int              DBW     = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);

  // Isolates the lowest set bit, so index 0 always wins.
  function automatic logic [4:0] lowest(input logic [4:0] v);
    return v & (~v + 5'd1);
  endfunction

  function automatic logic [2:0] encode(input logic [4:0] v);
    logic [2:0] code;
    code = '0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) code = 3'(i + 1);
    end
    return code;
  endfunction

  logic [4:0]     sync1, sync2;
  logic [4:0]     db, db_d;
  logic [DBW-1:0] db_cnt [5];
  logic [4:0]     rise;
  logic [4:0]     rpt_vec;
  logic [4:0]     press_q;

  assign rise = db & ~db_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_d    <= '0;
      press_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      db_d    <= db;
      press_q <= rise | rpt_vec;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

`ifdef BTN_CMD_REPEAT_EN
  localparam int             RW       = $clog2(RPT_CYCLES);
  localparam logic [RW-1:0]  RPT_LAST = RW'(RPT_CYCLES - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_restart;

  // Any new press or change of the lowest held button restarts the interval.
  assign rpt_restart = (|rise) || (lowest(db) != lowest(db_d)) || (db == '0);
  assign rpt_vec     = (!rpt_restart && rpt_cnt == RPT_LAST) ? lowest(db) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     rpt_cnt <= '0;
    else if (rpt_restart || rpt_cnt == RPT_LAST) rpt_cnt <= '0;
    else                                         rpt_cnt <= rpt_cnt + 1'b1;
  end
`else
  assign rpt_vec = '0;
`endif

  logic [2:0] mem   [4];
  logic [2:0] mem_n [4];
  logic [1:0] head, tail, head_n, tail_n;
  logic [2:0] level_n;
  logic       push, pop, push_ok;

  assign push    = |press_q;
  assign pop     = ack && valid;
  assign push_ok = push && (level != 3'd4 || pop);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_n   = mem;
    head_n  = head;
    tail_n  = tail;
    level_n = level;
    if (pop) begin
      head_n  = head + 2'd1;
      level_n = level_n - 3'd1;
    end
    if (push_ok) begin
      mem_n[tail] = encode(press_q);
      tail_n      = tail + 2'd1;
      level_n     = level_n + 3'd1;
    end
  end

  // NOTE: the FIFO storage is reset too, so cmd can never expose stale contents after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      head  <= '0;
      tail  <= '0;
      level <= '0;
      valid <= 1'b0;
      cmd   <= '0;
      ovf   <= 1'b0;
    end else begin
      mem   <= mem_n;
      head  <= head_n;
      tail  <= tail_n;
      level <= level_n;
      valid <= (level_n != 3'd0);
      cmd   <= (level_n != 3'd0) ? mem_n[head_n] : 3'd0;
      ovf   <= ovf | (push && !push_ok);
    end
  end

endmodule

// File: tb/tb_btn_cmd_in.sv
// Randomized plus directed bench for btn_cmd_in against a queue-based behavioural model.
module tb_btn_cmd_in;

  localparam int DB  = 16;
  localparam int RPT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn = '0;
  logic       ack = 1'b0;
  logic [2:0] cmd, level;
  logic       valid, ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_cmd_in #(.DB_CYCLES(DB), .RPT_CYCLES(RPT)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .ack  (ack),
    .cmd  (cmd),
    .valid(valid),
    .level(level),
    .ovf  (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sample history decides debounced levels, a queue holds commands.
  logic [4:0] raw_d1 = '0, raw_d2 = '0;
  logic [4:0] hist[$];
  logic [4:0] m_db = '0;
  int         evt1 = 0, evt2 = 0;
  int         mq[$];
  bit         m_ovf = 1'b0;
  int         age = 0;
  bit         restart = 1'b0;

  function automatic int lowcode(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    raw_d1 = '0; raw_d2 = '0; hist.delete(); m_db = '0;
    evt1 = 0; evt2 = 0; mq.delete(); m_ovf = 1'b0; age = 0; restart = 1'b0;
  endtask

  task automatic model_step();
    logic [4:0] seen, old, up;
    int         fire;
    bit         same;
    seen = raw_d2; raw_d2 = raw_d1; raw_d1 = btn;
    hist.push_back(seen);
    if (hist.size() > DB) void'(hist.pop_front());
    if (ack && mq.size() > 0) void'(mq.pop_front());
    if (evt2 != 0) begin
      if (mq.size() < 4) mq.push_back(evt2);
      else m_ovf = 1'b1;
    end
    fire = 0;
`ifdef BTN_CMD_REPEAT_EN
    if (restart || m_db == '0) age = 0;
    else if (age == RPT - 1) begin fire = lowcode(m_db); age = 0; end
    else age++;
`endif
    evt2 = (evt1 != 0) ? evt1 : fire;
    old = m_db;
    if (hist.size() == DB) begin
      for (int b = 0; b < 5; b++) begin
        same = 1'b1;
        foreach (hist[k]) if (hist[k][b] != hist[0][b]) same = 1'b0;
        if (same && hist[0][b] != m_db[b]) m_db[b] = hist[0][b];
      end
    end
    up      = m_db & ~old;
    evt1    = lowcode(up);
    restart = (up != '0) || (lowcode(m_db) != lowcode(old));
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    check("cmd",   cmd,   (mq.size() > 0) ? mq[0] : 0);
    check("valid", valid, mq.size() > 0);
    check("level", level, mq.size());
    check("ovf",   ovf,   m_ovf);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic press(input logic [4:0] v);
    btn = v; cyc(25);
    btn = '0; cyc(25);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc(2);
  endtask

  initial begin
    #1 rst = 1'b1;
    cyc(3);
    check("reset_cmd", cmd, 0);
    check("reset_valid", valid, 0);
    check("reset_level", level, 0);
    check("reset_ovf", ovf, 0);
    rst = 1'b0; cyc(2);

    // Latency from raw press to valid, then a long hold with one command only.
    btn = 5'b00001;
    cyc(19);
    check("lat_not_yet", valid, 0);
    cyc(1);
    check("lat_valid", valid, 1);
    check("lat_cmd", cmd, 1);
    check("lat_level", level, 1);
    cyc(40);
    check("hold_level", level, 1);
    btn = '0; cyc(25);
    ack = 1'b1; cyc(1); ack = 1'b0;
    check("drain_valid", valid, 0);

    // Bouncing contact never settles long enough.
    for (int i = 0; i < 20; i++) begin
      btn[2] = ~btn[2]; cyc(5);
    end
    btn = '0; cyc(40);
    check("bounce_valid", valid, 0);

    // Simultaneous presses keep only the lowest index.
    btn = 5'b01010; cyc(30);
    check("multi_cmd", cmd, 2);
    check("multi_level", level, 1);
    check("multi_ovf", ovf, 0);
    btn = '0; cyc(30);
    ack = 1'b1; cyc(1); ack = 1'b0;

    // Overflow and FIFO order.
    for (int k = 0; k < 5; k++) press(5'(1 << k));
    check("full_level", level, 4);
    check("full_ovf", ovf, 1);
    for (int k = 1; k <= 4; k++) begin
      check("order_cmd", cmd, k);
      ack = 1'b1; cyc(1);
    end
    ack = 1'b0;
    check("empty_valid", valid, 0);
    check("empty_cmd", cmd, 0);
    check("ovf_sticky", ovf, 1);
    do_reset();

    // Push and pop in the same cycle at level 4.
    for (int k = 0; k < 4; k++) press(5'(1 << k));
    btn = 5'b10000;
    cyc(19);
    ack = 1'b1; cyc(1); ack = 1'b0;
    check("pp_level", level, 4);
    check("pp_ovf", ovf, 0);
    for (int k = 2; k <= 5; k++) begin
      check("pp_order", cmd, k);
      ack = 1'b1; cyc(1);
    end
    ack = 1'b0; btn = '0;
    check("pp_empty", valid, 0);
    cyc(30);

    // Random buttons and acks against the model.
    for (int it = 0; it < 40; it++) begin
      int hold;
      btn  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      hold = $urandom_range(1, 90);
      for (int t = 0; t < hold; t++) begin
        ack = ($urandom_range(0, 2) == 0);
        cyc(1);
      end
    end
    btn = '0; ack = 1'b0;
    cyc(30);

`ifdef BTN_CMD_REPEAT_EN
    do_reset();
    btn = 5'b01000;
    begin
      int n;
      n = 0;
      while (valid !== 1'b1 && n < 100) begin cyc(1); n++; end
      check("rpt_accept_timeout", n < 100, 1);
    end
    cyc(200);
    check("rpt_level", level, 4);
    check("rpt_cmd", cmd, 4);
    check("rpt_ovf", ovf, 0);
    rst = 1'b1; #1;
    check("rst_cmd", cmd, 0);
    check("rst_valid", valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    cyc(2);
    rst = 1'b0; btn = '0;
    cyc(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
